serial_tx_1b: RTL
=================

Name: serial_tx_1b

Overview:
- Parallel-to-serial transmitter. Drives a single-bit serial line that feeds the 1-bit gate datapaths and their benches.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Emits a framed bit stream on tx: one start bit (0), data LSB-first, one stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Replaces hand-timed `#` stimulus on x with a synthesizable, cycle-exact source.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_data  input  DATA_W  word to transmit; sampled only on handshake.
- in_valid  input  1  producer has a word.
- in_ready  output  1  transmitter can accept; high only in IDLE.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is in progress (START/DATA/STOP).
- done  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, tx=1, busy=0, done=0, in_ready=1. Shift register and counters are cleared.
- Reset mid-frame: the frame is aborted. tx returns to 1 at that edge, no done pulse is issued, and the word is discarded.
- States: IDLE, START, DATA, STOP. Encoding is defined in the shared header.
- IDLE:
  - tx=1, in_ready=1.
  - On an edge with in_valid&&in_ready: latch in_data into the shift register, bit_idx=0, clk_cnt=0, go to START.
  - tx=0 is visible in the cycle after the accepting edge (latency 1).
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles.
  - Then shift right one bit and bit_idx+1.
  - After bit DATA_W-1 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - done=1 during the last of these cycles.
  - Then IDLE, with in_ready=1 the next cycle.
- Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
- Back-to-back transfers with in_valid held high: one IDLE cycle between frames, so period = (DATA_W+2)*CLKS_PER_BIT+1 cycles.
- in_data and in_valid are ignored while busy. A word is never accepted or lost outside IDLE.
- busy = (state != IDLE). in_ready = (state == IDLE). Both are state-decoded with no combinational path from inputs.
- Counter widths:
  - clk_cnt: $clog2(CLKS_PER_BIT) bits, minimum 1; wraps from CLKS_PER_BIT-1 to 0.
  - bit_idx: $clog2(DATA_W) bits, minimum 1.
- CLKS_PER_BIT=1: every state advances each cycle; done coincides with the single stop cycle.
- No X on any output after the first reset edge.

Decomposition:
- Shared header serial_defs.vh holds the state encoding localparams (ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3) plus the TX_IDLE_LEVEL=1 and TX_START_LEVEL=0 constants.
- One sub-module, bit_tick_gen:
  - Parameter: CLKS_PER_BIT.
  - Ports: clk, rst_n, clear, tick.
  - tick is high on the last cycle of each bit period.
  - clear restarts the count on frame start.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, in_valid=0 for 20 cycles -> tx=1, in_ready=1, busy=0, done=0 throughout.
- Single frame, defaults: send 8'hA5 -> after 1 cycle, tx is 0 for 4 clks, then 1,0,1,0,0,1,0,1 (4 clks each), then 1 for 4 clks. done pulses once at cycle 40 of the frame; busy is high for exactly 40 cycles.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF -> second start bit begins exactly 41 cycles after the first. Decoded bytes are 00, FF; exactly two done pulses.
- Ignore while busy: change in_data to 8'h3C mid-frame of 8'h81 with in_valid=1 -> the line carries 8'h81 only, and 8'h3C is accepted in the next IDLE.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 8'h5A -> tx=1 at that edge, no done pulse, in_ready=1 after release. A following 8'hC3 transmits correctly.
- CLKS_PER_BIT=1, DATA_W=4: send 4'b1001 -> tx sequence 0,1,0,0,1,1 on consecutive cycles; done is on the 6th.

Source files
------------

// File: rtl/serial_tx_1b_pkg.sv
// Shared definitions for the serial_tx_1b transmitter: state encoding,
// line levels and a counter-width helper.
package serial_tx_1b_pkg;

    // Frame sequencer states; the numeric encoding is fixed so that other
    // blocks and debug tooling can decode the state bus.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Line level while idle and during the stop bit.
    localparam logic TX_IDLE_LEVEL  = 1'b1;
    // Line level during the start bit.
    localparam logic TX_START_LEVEL = 1'b0;

    // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_1b_bit_tick_gen.sv
// Bit-period timer: counts clocks within one serial bit and flags the last
// cycle of each bit period.
module bit_tick_gen
    import serial_tx_1b_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;

    // Count clocks within a bit period, wrapping after the last one; held at 0 while cleared.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge values of its neighbours, independent of block ordering.
        if (!rst_n || clear) begin
            clk_cnt <= '0;
        end else if (clk_cnt == LAST) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
        end
    end

    // The tick is suppressed while cleared so an idle transmitter never advances.
    assign tick = !clear && (clk_cnt == LAST);

endmodule

// File: rtl/serial_tx_1b.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and sends
// start bit (0), data LSB-first, stop bit (1), each held CLKS_PER_BIT clocks.
module serial_tx_1b
    import serial_tx_1b_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int                IDX_W    = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_nxt;
    logic              tx_nxt;
    logic              tick;
    logic              tick_clear;

    // The bit timer restarts from zero whenever a frame begins.
    assign tick_clear = (state == ST_IDLE);

    bit_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Next-state, shift and line-level decode; tx_nxt is the level the line takes after this edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        tx_nxt      = TX_IDLE_LEVEL;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt   = ST_START;
                    shift_nxt   = in_data;
                    bit_idx_nxt = '0;
                    tx_nxt      = TX_START_LEVEL;
                end
            end
            ST_START: begin
                tx_nxt = TX_START_LEVEL;
                if (tick) begin
                    state_nxt = ST_DATA;
                    tx_nxt    = shift[0];
                end
            end
            ST_DATA: begin
                tx_nxt = shift[0];
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = ST_STOP;
                        tx_nxt    = TX_IDLE_LEVEL;
                    end else begin
                        shift_nxt   = shift >> 1;
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                        tx_nxt      = shift_nxt[0];
                    end
                end
            end
            ST_STOP: begin
                tx_nxt = TX_IDLE_LEVEL;
                if (tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered line; reset aborts any frame and forces the line idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            // NOTE: the shift register is datapath but is cleared anyway so
            // no X can reach tx after the first reset edge.
            shift   <= '0;
            bit_idx <= '0;
            tx      <= TX_IDLE_LEVEL;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            tx      <= tx_nxt;
        end
    end

    // Handshake and status are pure state decodes, with no path from the inputs.
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_STOP) && tick;

endmodule
